// File: rtl/mm_sequencer.sv
// mm_sequencer: UART-fed matrix-multiply sequencer.
// Loads A and B bytes, starts the multiplier, then streams the result out MSB first.
module mm_sequencer #(
    parameter int N           = 2,
    parameter int RES_BYTES   = 2,
    parameter int TIMEOUT_CYC = 0,
    localparam int LOAD_BYTES = 2 * N * N,
    localparam int AW = ($clog2(LOAD_BYTES) < 1) ? 1 : $clog2(LOAD_BYTES),
    localparam int RW = ($clog2(N * N) < 1) ? 1 : $clog2(N * N),
    localparam int BW = ($clog2(RES_BYTES) < 1) ? 1 : $clog2(RES_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic          tx_busy,
    input  logic          mult_done,
    output logic          rx_enable,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          mult_start,
    output logic          tx_start,
    output logic [RW-1:0] rd_addr,
    output logic [BW-1:0] byte_sel,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int SW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = (SW_RAW < 1) ? 1 : SW_RAW;

    localparam logic [AW-1:0] CNT_LAST   = AW'(LOAD_BYTES - 1);
    localparam logic [RW-1:0] RD_LAST    = RW'(N * N - 1);
    localparam logic [BW-1:0] BS_LAST    = BW'(RES_BYTES - 1);
    localparam logic [SW-1:0] STALL_LAST =
        (TIMEOUT_CYC > 0) ? SW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        START,
        COMPUTE,
        TX_WAIT,
        TX_PULSE,
        TX_ACK,
        TX_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [BW-1:0] bs_q, bs_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rx_en;
    logic          rx_hit;
    logic          stall_st;

    // Moore-style outputs decoded from the registered state
    always_comb begin
        rx_en      = (state_q == IDLE) || (state_q == RECV);
        rx_hit     = rx_valid && rx_en;
        stall_st   = (state_q == RECV) || (state_q == TX_ACK);
        rx_enable  = rx_en;
        wr_en      = rx_hit;
        wr_addr    = cnt_q;
        mult_start = (state_q == START);
        tx_start   = (state_q == TX_PULSE);
        busy       = (state_q != IDLE);
        rd_addr    = rd_q;
        byte_sel   = bs_q;
        done       = done_q;
        err        = err_q;
    end

    // Next-state, counters, result pointer and stall timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        bs_d    = bs_q;
        stall_d = stall_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    cnt_d   = AW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            START: begin
                state_d = COMPUTE;
            end
            COMPUTE: begin
                if (mult_done) begin
                    rd_d    = '0;
                    bs_d    = '0;
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!tx_busy) state_d = TX_PULSE;
            end
            TX_PULSE: begin
                state_d = TX_ACK;
            end
            TX_ACK: begin
                if (tx_busy) state_d = TX_DRAIN;
            end
            TX_DRAIN: begin
                if (!tx_busy) begin
                    state_d = TX_WAIT;
                    if (bs_q == BS_LAST) begin
                        bs_d = '0;
                        if (rd_q == RD_LAST) begin
                            rd_d    = '0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            rd_d = rd_q + RW'(1);
                        end
                    end else begin
                        bs_d = bs_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d != state_q) || rx_hit) begin
            stall_d = '0;
        end else if (stall_st && (TIMEOUT_CYC != 0)) begin
            if (stall_q == STALL_LAST) begin
                state_d = IDLE;
                err_d   = 1'b1;
                cnt_d   = '0;
                rd_d    = '0;
                bs_d    = '0;
                stall_d = '0;
            end else begin
                stall_d = stall_q + SW'(1);
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            bs_q    <= '0;
            stall_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            bs_q    <= bs_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer: scoreboard bench for mm_sequencer.
// Expected events are queued by stimulus and popped by a negedge monitor.
module tb_mm_sequencer;

    localparam int K_WR   = 0;
    localparam int K_MS   = 1;
    localparam int K_TX   = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic       tx_busy;
    logic       mult_done;
    logic       rx_enable;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic       mult_start;
    logic       tx_start;
    logic [1:0] rd_addr;
    logic [0:0] byte_sel;
    logic       busy;
    logic       done;
    logic       err;

    mm_sequencer #(
        .N(2),
        .RES_BYTES(2),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_valid(rx_valid),
        .tx_busy(tx_busy),
        .mult_done(mult_done),
        .rx_enable(rx_enable),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .mult_start(mult_start),
        .tx_start(tx_start),
        .rd_addr(rd_addr),
        .byte_sel(byte_sel),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int a;
        int b;
        int stamp;
    } ev_t;

    ev_t  expq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic force_busy = 1'b0;
    int   bcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int a, input int b,
                           input int stamp);
        ev_t e;
        e.kind  = kind;
        e.a     = a;
        e.b     = b;
        e.stamp = stamp;
        expq.push_back(e);
    endtask

    task automatic observe(input int kind, input int a, input int b);
        ev_t e;
        if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d (%0d,%0d) expected none (cycle %0d)",
                     kind, a, b, cyc);
        end else begin
            e = expq.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                check("event_a", a, e.a);
                check("event_b", b, e.b);
                if (e.stamp >= 0) check("event_cycle", cyc, e.stamp);
            end
        end
    endtask

    // Monitor: every output event pops one expected entry
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) observe(K_WR, int'(wr_addr), 0);
            if (mult_start) observe(K_MS, 0, 0);
            if (tx_start) observe(K_TX, int'(rd_addr), int'(byte_sel));
            if (done) observe(K_DONE, 0, 0);
            if (err) observe(K_ERR, 0, 0);
        end
    end

    // UART TX model: busy for 5 cycles after each tx_start
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt    = 0;
                tx_busy = 1'b0;
            end else if (force_busy) begin
                tx_busy = 1'b1;
            end else if (tx_start) begin
                bcnt    = 5;
                tx_busy = 1'b1;
            end else if (bcnt > 0) begin
                bcnt--;
                tx_busy = (bcnt > 0);
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input int addr);
        @(posedge clk);
        #1;
        push_ev(K_WR, addr, 0, cyc);
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic load();
        for (int i = 0; i < 8; i++) send_byte(i);
        push_ev(K_MS, 0, 0, cyc);
    endtask

    task automatic push_tx(input int nbytes);
        for (int j = 0; j < nbytes; j++) push_ev(K_TX, j / 2, j % 2, -1);
    endtask

    task automatic run_mult(input bit poke, input bit hold);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mult_start) break;
        end
        if (k == 20) check("mult_start_timeout", 0, 1);
        if (hold) force_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            rx_valid = poke && (i % 3 == 1);
            @(negedge clk);
            if (rx_valid) begin
                check("wr_en_compute", int'(wr_en), 0);
                check("wr_addr_compute", int'(wr_addr), 0);
            end
        end
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        mult_done = 1'b1;
        @(posedge clk);
        #1;
        mult_done = 1'b0;
        if (hold) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check("no_tx_while_busy", int'(tx_start), 0);
            end
            @(posedge clk);
            #1;
            force_busy = 1'b0;
        end
    endtask

    task automatic wait_done(input bit poke);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            rx_valid = poke && busy && (rd_addr < 2'd3) && (k % 5 == 2);
            @(negedge clk);
            if (rx_valid) begin
                check("wr_en_tx", int'(wr_en), 0);
                check("wr_addr_tx", int'(wr_addr), 0);
            end
            if (done) break;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (k == 400) check("done_timeout", 0, 1);
        check("busy_after_done", int'(busy), 0);
    endtask

    task automatic full_txn(input bit poke, input bit hold);
        load();
        push_tx(8);
        push_ev(K_DONE, 0, 0, -1);
        run_mult(poke, hold);
        wait_done(poke);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_rx_enable"}, int'(rx_enable), 1);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_wr_addr"}, int'(wr_addr), 0);
        check({tag, "_mult_start"}, int'(mult_start), 0);
        check({tag, "_tx_start"}, int'(tx_start), 0);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_byte_sel"}, int'(byte_sel), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        rx_valid  = 1'b0;
        mult_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full load, compute, transmit with stray rx_valid pulses
        full_txn(1'b1, 1'b0);

        // tx_busy held high when the multiply finishes
        full_txn(1'b0, 1'b1);

        // Reset in TX_ACK while sending element 2
        load();
        push_tx(5);
        run_mult(1'b0, 1'b0);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_start && rd_addr == 2'd2) break;
        end
        if (k == 200) check("elem2_timeout", 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        check("queue_after_rst", expq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_rst", int'(busy), 0);
        full_txn(1'b0, 1'b0);

        // Stall timeout after 3 bytes
        send_byte(0);
        send_byte(1);
        send_byte(2);
        push_ev(K_ERR, 0, 0, cyc + 16);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (err) break;
        end
        if (k == 40) check("err_timeout", 0, 1);
        @(posedge clk);
        #1;
        check("busy_after_err", int'(busy), 0);
        check("wr_addr_after_err", int'(wr_addr), 0);
        full_txn(1'b0, 1'b0);

        repeat (5) @(posedge clk);
        check("queue_empty", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mm_sequencer.md
MM_SEQUENCER -- requirements
Module: mm_sequencer

Interface
REQ-001 Parameter N, default 2: matrix dimension; N >= 1.
REQ-002 Parameter RES_BYTES, default 2: UART bytes per result element; >= 1.
REQ-003 Parameter TIMEOUT_CYC, default 0: stall timeout in clk cycles; 0 disables the timeout.
REQ-004 Derived: LOAD_BYTES = 2*N*N; AW = max(1, clog2(LOAD_BYTES)); RW = max(1, clog2(N*N)); BW = max(1, clog2(RES_BYTES)).
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst  in  1  reset: one clock; reset is asynchronous and active-high.
REQ-007 rx_valid  in  1  one-cycle pulse per received UART byte.
REQ-008 tx_busy  in  1  UART TX busy level.
REQ-009 mult_done  in  1  multiplier completion (pulse or level).
REQ-010 rx_enable  out  1  UART RX enabled.
REQ-011 wr_en  out  1  write the current RX byte to the operand buffer.
REQ-012 wr_addr  out  AW  operand buffer byte address (A bytes 0..N*N-1, then B bytes).
REQ-013 mult_start  out  1  one-cycle multiply start pulse.
REQ-014 tx_start  out  1  one-cycle UART TX start pulse.
REQ-015 rd_addr  out  RW  result element index being sent.
REQ-016 byte_sel  out  BW  byte within element; 0 = most significant byte.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse: full result transmitted.
REQ-019 err  out  1  one-cycle pulse: timeout abort.

Function
REQ-020 States SHALL be IDLE, RECV, START, COMPUTE, TX_WAIT, TX_PULSE, TX_ACK, TX_DRAIN.
REQ-021 rx_enable = 1 in IDLE and RECV only; wr_en = rx_valid AND rx_enable; wr_addr = byte counter.
REQ-022 IDLE: rx_valid writes byte 0, counter -> 1, next RECV.
REQ-023 RECV: each rx_valid writes at counter and increments it; the write at LOAD_BYTES-1 moves to START, counter -> 0.
REQ-024 START: mult_start = 1 for exactly one cycle; next COMPUTE.
REQ-025 COMPUTE: hold until mult_done sampled 1; then TX_WAIT with rd_addr = 0, byte_sel = 0; mult_done in any other state ignored.
REQ-026 TX_WAIT: tx_busy = 0 -> TX_PULSE; TX_PULSE: tx_start = 1 for one cycle -> TX_ACK.
REQ-027 TX_ACK: tx_busy = 1 -> TX_DRAIN; TX_DRAIN: tx_busy = 0 -> advance pointer.
REQ-028 Advance: byte_sel increments; at RES_BYTES-1 it wraps to 0 and rd_addr increments; after byte RES_BYTES-1 of element N*N-1 -> IDLE with done pulsed, else TX_WAIT.
REQ-029 rd_addr/byte_sel SHALL be stable from TX_WAIT entry until TX_DRAIN exit.
REQ-030 Stall counter: clears on state change and on rx_valid; increments each cycle in RECV or TX_ACK; reaching TIMEOUT_CYC (nonzero) -> IDLE, err pulsed, counters cleared.
REQ-031 done and err SHALL be registered, high exactly the first cycle after the terminating transition.
REQ-032 rx_valid outside IDLE/RECV SHALL be ignored (no write, no count change).
REQ-033 Total latency, last RX byte to mult_start = 1 cycle (registered state).

Reset
REQ-034 While rst = 1: state IDLE; counters, rd_addr, byte_sel, wr_addr = 0; mult_start, tx_start, done, err, busy, wr_en = 0; rx_enable = 1.
REQ-035 rst asserted mid-operation SHALL abort immediately, with no done/err pulse; operation resumes from IDLE after release.

Verification
REQ-036 N=2, RES_BYTES=2: 8 rx_valid pulses -> wr_en with wr_addr 0..7, mult_start high one cycle, cycle after 8th byte.
REQ-037 mult_done after 10 cycles, tx_busy modelled 1 for 5 cycles per tx_start -> 8 tx_start pulses, (rd_addr,byte_sel) = (0,0),(0,1),(1,0)...(3,1), done one cycle after last drain.
REQ-038 TIMEOUT_CYC=16, 3 bytes then silence -> err pulse 16 cycles after 3rd byte, state IDLE, next byte written at wr_addr 0.
REQ-039 rx_valid pulses during COMPUTE and TX states -> no wr_en, wr_addr unchanged.
REQ-040 rst pulse in TX_ACK at element 2 -> all outputs at reset values, no done; new 8-byte load works.
REQ-041 tx_busy held 1 at COMPUTE exit -> no tx_start until tx_busy falls.
